universal_shift_reg_seq: RTL
============================

UNIVERSAL_SHIFT_REG_SEQ -- requirements
Module: universal_shift_reg_seq

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter AMT_W, default 4, width of the burst shift-count input.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clear  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  operation enable; 0 holds all state and stalls a running burst.
REQ-006 S  input  3  mode select (see REQ-012).
REQ-007 I  input  WIDTH  parallel load data.
REQ-008 sr_in  input  1  serial input entering O[WIDTH-1] on shift-right.
REQ-009 sl_in  input  1  serial input entering O[0] on shift-left.
REQ-010 start, amt  input  1, AMT_W  burst request; amt = number of single-position steps.
REQ-011 O  output  WIDTH  register contents; sr_out output 1 = O[0]; sl_out output 1 = O[WIDTH-1]; busy output 1 burst running; done output 1 one-cycle burst-complete pulse.

Function
REQ-012 Single-step modes SHALL be: 000 hold; 001 load zero; 010 shift right (O <= {sr_in, O[WIDTH-1:1]}); 011 parallel load I; 100 bitwise complement; 101 shift left (O <= {O[WIDTH-2:0], sl_in}); 110 rotate right; 111 rotate left.
REQ-013 FSM SHALL have two states, IDLE and RUN; reset state IDLE.
REQ-014 In IDLE with en=1 and start=0, O SHALL take the REQ-012 result of S at the next edge.
REQ-015 In IDLE with en=1, start=1 and S in {010,101,110,111} ("burst modes"), the block SHALL latch S and amt and leave O unchanged at that edge.
REQ-016 If latched amt is 0, the block SHALL stay in IDLE, keep busy=0 and assert done for the following cycle.
REQ-017 If latched amt is N>0, the block SHALL enter RUN with busy=1 from the cycle after the start edge.
REQ-018 In RUN, each edge with en=1 SHALL apply one step of the latched mode and decrement the remaining count; S, I, start and amt SHALL be ignored.
REQ-019 sr_in/sl_in SHALL be sampled at every step edge, not latched at start.
REQ-020 In RUN, en=0 SHALL freeze O and the remaining count; busy stays 1.
REQ-021 On the step edge that brings the remaining count to 0, the block SHALL return to IDLE, drop busy and assert done for exactly one cycle.
REQ-022 An N-step burst with en held 1 SHALL occupy exactly N edges after the start edge; done is high in the cycle after edge N.
REQ-023 N may exceed WIDTH: rotates SHALL wrap modulo WIDTH; shifts SHALL continue filling with the serial input.
REQ-024 start=1 with a non-burst S (000,001,011,100) SHALL be treated as start=0 (single-step op, no busy, no done).
REQ-025 start=1 with en=0 in IDLE SHALL be ignored.
REQ-026 A new start SHALL be accepted in the same cycle done is high (back-to-back bursts).
REQ-027 sr_out and sl_out SHALL be combinational copies of O[0] and O[WIDTH-1].

Reset
REQ-028 clear=1 at an edge SHALL force O=0, busy=0, done=0, remaining count=0, state IDLE, regardless of en, start or state.
REQ-029 clear asserted mid-burst SHALL abort the burst with no done pulse.
REQ-030 clear SHALL take priority over every other input in the same cycle.

Verification (WIDTH=8, AMT_W=4)
REQ-031 clear=1 one edge, then S=011, I=8'hA5, en=1 -> O=8'h00 after clear edge, O=8'hA5 after next edge; busy=0, done=0 throughout.
REQ-032 O=8'hA5, S=110, start=1, amt=3, en=1 -> busy=1 for 3 cycles, O=8'hB4 after edge 3, done=1 for one cycle, then busy=0.
REQ-033 O=8'h81, S=101, sl_in=1, start, amt=4, en dropped for 2 cycles mid-burst -> busy=1 for 6 cycles, final O=8'h1F, single done pulse.
REQ-034 O=8'hFF, S=010, sr_in=0, start, amt=10 -> O=8'h00 after 10 steps; O=8'h0F visible after step 4.
REQ-035 start with amt=0 -> O unchanged, busy never 1, done=1 one cycle; start with S=100 -> O complemented once, no done.
REQ-036 clear asserted after step 2 of an amt=5 rotate -> O=8'h00, busy=0 next cycle, no done pulse; subsequent start accepted normally.

Source files
------------

// File: rtl/universal_shift_reg_seq.sv
// ---------------------------------------------------------------------------
// universal_shift_reg_seq
//   Universal shift register. It performs single-step operations and also runs
//   multi-step bursts under control of a small IDLE/RUN sequencer.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   clear    : synchronous active-high reset, highest priority
//   en       : operation enable; low holds state and stalls a running burst
//   S        : mode select (hold/zero/shr/load/not/shl/ror/rol)
//   I        : parallel load data
//   sr_in    : serial input shifted into O[WIDTH-1] on shift-right
//   sl_in    : serial input shifted into O[0] on shift-left
//   start    : burst request (only honoured for shift/rotate modes)
//   amt      : burst length in single-position steps
//   O        : register contents
//   sr_out   : O[0]
//   sl_out   : O[WIDTH-1]
//   busy     : burst in progress
//   done     : one-cycle pulse after a burst completes (or a zero-length burst)
// ---------------------------------------------------------------------------
module universal_shift_reg_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic [2:0]       S,
   input  logic [WIDTH-1:0] I,
   input  logic             sr_in,
   input  logic             sl_in,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] O,
   output logic             sr_out,
   output logic             sl_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      M_HOLD = 3'b000,
      M_ZERO = 3'b001,
      M_SHR  = 3'b010,
      M_LOAD = 3'b011,
      M_NOT  = 3'b100,
      M_SHL  = 3'b101,
      M_ROR  = 3'b110,
      M_ROL  = 3'b111
   } mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   mode_t            r_mode;
   logic [AMT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_O;
   logic             r_busy;
   logic             r_done;

   mode_t            w_mode;
   mode_t            w_sel;
   logic [WIDTH-1:0] w_next;
   logic             w_burst_req;

   assign w_sel = mode_t'(S);

   // The datapath is shared: RUN steps with the latched mode, IDLE with S.
   assign w_mode = (r_state == RUN) ? r_mode : w_sel;

   assign w_burst_req = start && ((w_sel == M_SHR) || (w_sel == M_SHL) ||
                                  (w_sel == M_ROR) || (w_sel == M_ROL));

   always_comb begin
      w_next = r_O;
      case (w_mode)
         M_HOLD:  w_next = r_O;
         M_ZERO:  w_next = '0;
         M_SHR:   w_next = {sr_in, r_O[WIDTH-1:1]};
         M_LOAD:  w_next = I;
         M_NOT:   w_next = ~r_O;
         M_SHL:   w_next = {r_O[WIDTH-2:0], sl_in};
         M_ROR:   w_next = {r_O[0], r_O[WIDTH-1:1]};
         M_ROL:   w_next = {r_O[WIDTH-2:0], r_O[WIDTH-1]};
         default: w_next = r_O;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         r_state <= IDLE;
         r_mode  <= M_HOLD;
         r_cnt   <= '0;
         r_O     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (en) begin
                  if (w_burst_req) begin
                     // Start edge only latches the request; O is untouched.
                     r_mode <= w_sel;
                     if (amt == '0) begin
                        r_done <= 1'b1;
                     end else begin
                        r_cnt   <= amt;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                     end
                  end else begin
                     r_O <= w_next;
                  end
               end
            end
            RUN: begin
               if (en) begin
                  r_O   <= w_next;
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == AMT_W'(1)) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign O      = r_O;
   assign sr_out = r_O[0];
   assign sl_out = r_O[WIDTH-1];
   assign busy   = r_busy;
   assign done   = r_done;

endmodule
